// File: rtl/e5rv32_pkg.sv
// Shared RV32 core types: XLEN, M-extension funct3 encoding and mul/div FSM states.
package e5rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: done 34 cycles after accept (1 for div-by-zero/overflow).
// No backpressure: start is taken only in IDLE/DONE, ignored while busy; flush aborts.
module muldiv_unit
  import e5rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] wd,
  output logic [4:0]      wa,
  output logic            we
);

  muldiv_state_e   state;
  muldiv_op_e      op_in;
  muldiv_op_e      op_q;
  logic [5:0]      cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] opb_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            rem_neg_q;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  assign op_in = muldiv_op_e'(op);

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign is_div   = op[2];
  assign div_zero = is_div && (b == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                    (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign fast     = div_zero || div_ovf;

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    if (div_zero) fast_res = op[1] ? a : '1;
    else          fast_res = op[1] ? '0 : 32'h8000_0000;
  end

  // Multiply: acc = {partial sum, remaining multiplier bits}, shift right each step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opa_q & {XLEN{acc[0]}}};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Divide: acc = {remainder, dividend shifting out / quotient shifting in}
  logic [XLEN:0]     div_rem;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic              unused_diff_bit;
  assign div_rem  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = {1'b0, div_rem} - {2'b0, opb_q};
  assign div_ge   = ~div_diff[XLEN+1];
  assign div_next = {div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0], acc[XLEN-2:0], div_ge};
  assign unused_diff_bit = div_diff[XLEN];

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;
  assign prod = neg_q ? -acc : acc;
  assign quo  = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = neg_q ? -quo : quo;
      default:                      fix_res = rem_neg_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we        <= 1'b0;
      wd        <= '0;
      wa        <= '0;
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              op_q      <= op_in;
              rd_q      <= rd;
              opa_q     <= a_mag;
              opb_q     <= b_mag;
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              cnt       <= '0;
              acc       <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
              if (fast) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                we    <= (rd != 5'd0);
                wd    <= fast_res;
                wa    <= rd;
              end else begin
                state <= ST_CALC;
                busy  <= 1'b1;
              end
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          ST_CALC: begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= ST_FIX;
          end
          ST_FIX: begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            we    <= (rd_q != 5'd0);
            wd    <= fix_res;
            wa    <= rd_q;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 The ports SHALL be as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request valid; operands, op and rd are sampled when accepted.
- flush  in  1  abort any operation in flight.
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  32  rs1 operand (register-file read port 1).
- b  in  32  rs2 operand (register-file read port 2).
- rd  in  5  destination register index.
- busy  out  1  high while an operation occupies the unit.
- done  out  1  one-cycle result-valid pulse.
- wd  out  32  result, routed to the register-file write data.
- wa  out  5  destination index, routed to the register-file write address.
- we  out  1  register-file write enable, equal to done AND (wa != 0).

Function
REQ-003 The state machine SHALL have four states, with these transitions:
- IDLE -> CALC on an accepted start.
- CALC -> FIX after 32 iterations.
- FIX -> DONE.
- DONE -> IDLE, or DONE -> CALC if start is accepted in DONE.
REQ-004 start SHALL be accepted only in IDLE or DONE when flush=0; start in any other state SHALL be ignored.
REQ-005 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-006 The multiply path SHALL operate on operand magnitudes:
- unsigned shift-add, one bit per CALC cycle, 64-bit product;
- operands sign-interpreted per op (MULH both signed, MULHSU a signed, MULHU neither);
- product negated in FIX when the operand signs differ.
REQ-007 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-008 DIV/REM SHALL use a restoring algorithm on magnitudes, one quotient bit per CALC cycle.
REQ-009 In FIX, the signed DIV quotient SHALL be negated when the operand signs differ, and the signed REM remainder SHALL take the dividend's sign.
REQ-010 done SHALL assert exactly 34 cycles after the accept cycle (32 CALC, 1 FIX, then DONE) for the normal path.
REQ-011 Divide-by-zero (b=0) SHALL take the fast path: DIV/DIVU return 0xFFFFFFFF, REM/REMU return a.
REQ-012 Signed overflow (op DIV/REM, a=0x80000000, b=0xFFFFFFFF) SHALL take the fast path: DIV returns 0x80000000, REM returns 0.
REQ-013 The fast path SHALL go IDLE/DONE -> DONE directly, so done asserts 1 cycle after the accept cycle.
REQ-014 wd and wa SHALL hold the last result and index stable until the next DONE; done and we SHALL be 1 only in DONE.
REQ-015 rd=0 SHALL be computed normally, with done=1 and we=0.
REQ-016 flush SHALL return the FSM to IDLE on the next edge from any state, with no done for the aborted operation.
REQ-017 flush in DONE SHALL NOT cancel that cycle's done.
REQ-018 Simultaneous start and flush SHALL give flush priority, and start SHALL NOT be accepted.
REQ-019 Operands SHALL be latched at accept; changes on a, b, op or rd afterwards SHALL NOT affect the result.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, with busy=0, done=0, we=0, wd=0 and wa=0.
REQ-021 Reset SHALL clear the internal accumulator, operand registers and the 6-bit iteration counter to 0.
REQ-022 Reset asserted mid-operation SHALL discard the operation, and no done SHALL follow deassertion.
REQ-023 Deassertion of rst_n SHALL take effect at the next rising edge of clk.

Structure
REQ-024 The op encoding enum (muldiv_op_e), the state enum (muldiv_state_e) and XLEN=32 SHALL live in the shared package e5rv32_pkg.
REQ-025 The block SHALL be a single module with no sub-module; the counter, accumulator and sign-fixup logic SHALL be in-line.

Verification
REQ-026 MUL a=7, b=0xFFFFFFFD, rd=5 -> done at accept+34, wd=0xFFFFFFEB, wa=5, we=1.
REQ-027 MULHU a=b=0xFFFFFFFF -> wd=0xFFFFFFFE; MULH with the same operands -> wd=0x00000000.
REQ-028 DIV a=0x80000000, b=0xFFFFFFFF -> done at accept+1, wd=0x80000000; REMU a=7, b=0 -> done at accept+1, wd=7.
REQ-029 REM a=0xFFFFFFF9 (-7), b=2 -> wd=0xFFFFFFFF; DIV with the same operands -> wd=0xFFFFFFFD.
REQ-030 DIVU a=100, b=7, then flush at accept+10 -> busy=0 next cycle, no done; a new start accepted afterwards completes normally.
REQ-031 Back-to-back: start held in the DONE cycle with rd=0 -> second operation accepted, first done=1 with we=1, second done has we=0.
